// File: rtl/serial_adder.sv
`default_nettype none

// ============================================================================
// Module   : full_adder
// Purpose  : 1-bit full adder, the only arithmetic element of serial_adder.
// Ports    : a, b, ci - operand bits and carry-in
//            s        - sum bit
//            co       - carry-out
// Revision : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial adder. Accepts A, B and a carry-in with a valid/ready
//            handshake, adds one bit per cycle LSB first through a single
//            full adder, then presents the registered sum and carry-out with
//            a valid/ready handshake. One result every WIDTH+2 cycles.
// Ports    : clk       - clock, all state updates on the rising edge
//            rst_n     - synchronous active-low reset
//            in_valid  - operand set on a_in/b_in/cin is valid
//            in_ready  - block can accept an operand set (FSM in IDLE)
//            a_in      - addend A, WIDTH bits
//            b_in      - addend B, WIDTH bits
//            cin       - carry-in
//            sum_out   - (A+B+cin) mod 2^WIDTH, WIDTH bits
//            cout      - carry-out of the MSB
//            out_valid - sum_out/cout hold a valid result (FSM in DONE)
//            out_ready - downstream consumer takes the result
//            busy      - FSM is not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             fa_sum;
    logic             fa_carry;

    // ------------------------------------------------------------------------
    // The single arithmetic element: LSBs of both shift registers plus the
    // running carry.
    // ------------------------------------------------------------------------
    full_adder u_full_adder (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_sum),
        .co (fa_carry)
    );

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and outputs. DONE always passes through IDLE before a
    // new acceptance, which is what gives the WIDTH+2 cycle cadence.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                if (cnt == LAST_BIT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath. The carry flop doubles as cout and the sum shift register as
    // sum_out; neither is touched in DONE or IDLE, so the result stays on the
    // outputs until the next acceptance.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr   <= a_in;
                        b_sr   <= b_in;
                        carry  <= cin;
                        sum_sr <= '0;
                        cnt    <= '0;
                    end
                end
                ADD: begin
                    // Sum bits enter at the MSB; after WIDTH shifts the bit
                    // computed first has arrived at bit 0.
                    sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= fa_carry;
                    cnt    <= cnt + CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    assign sum_out = sum_sr;
    assign cout    = carry;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none

// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Self-checking bench for serial_adder (WIDTH=8) using directed
//            vectors with hand-computed results plus a reference-model sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic [WIDTH-1:0] sum_out;
    logic             cout;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    int total = 0;
    int bad   = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin       (cin),
        .sum_out   (sum_out),
        .cout      (cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operand set from IDLE, waits for the result, stalls for
    // 'stall' cycles, then releases it. Returns what was observed.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input int stall,
                          output logic [7:0] s, output logic co, output int lat,
                          output int busy_n, output bit hold_ok, output bit idle_ok,
                          output bit timeout);
        timeout = 1'b0; hold_ok = 1'b1; idle_ok = 1'b1;
        busy_n = 0; lat = 0; s = '0; co = 1'b0;
        a_in = a; b_in = b; cin = c; in_valid = 1'b1;
        out_ready = (stall == 0);
        tick();
        in_valid = 1'b0;
        a_in = ~a; b_in = ~b; cin = ~c;
        if (busy) busy_n++;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
            if (busy) busy_n++;
        end
        if (!out_valid) begin
            timeout = 1'b1;
            return;
        end
        s = sum_out; co = cout;
        for (int i = 0; i < stall; i++) begin
            tick();
            if (busy) busy_n++;
            if (!out_valid || sum_out !== s || cout !== co) hold_ok = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        if (busy) busy_n++;
        out_ready = 1'b0;
        if (busy || out_valid || !in_ready || sum_out !== s || cout !== co) idle_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; a_in = 8'h12; b_in = 8'h34; cin = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (sum_out !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h want=00", sum_out); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", cout); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_no_accept busy got=%b want=0", busy); end
    endtask

    task automatic test_basic();
        logic [7:0] s; logic co; int lat; int bn; bit h; bit id; bit to;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%b want=1", in_ready); end
        run_op(8'h5A, 8'h3C, 1'b0, 0, s, co, lat, bn, h, id, to);
        total++; if (to) begin bad++; $display("FAIL basic_timeout got=timeout want=out_valid"); end
        total++; if (lat != 8) begin bad++; $display("FAIL basic_latency got=%0d want=8", lat); end
        total++; if (s !== 8'h96) begin bad++; $display("FAIL basic_sum got=%h want=96", s); end
        total++; if (co !== 1'b0) begin bad++; $display("FAIL basic_cout got=%b want=0", co); end
        total++; if (bn != 9) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=9", bn); end
        total++; if (!id) begin bad++; $display("FAIL basic_return_idle got=%b want=1", id); end
    endtask

    task automatic test_carry();
        logic [7:0] va [4] = '{8'hFF, 8'hFF, 8'h00, 8'h7F};
        logic [7:0] vb [4] = '{8'h01, 8'h00, 8'h00, 8'h01};
        logic       vc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] es [4] = '{8'h00, 8'h00, 8'h00, 8'h80};
        logic       ec [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] s; logic co; int lat; int bn; bit h; bit id; bit to;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vc[i], 0, s, co, lat, bn, h, id, to);
            total++; if (to || s !== es[i] || co !== ec[i]) begin
                bad++; $display("FAIL carry_vec%0d got=%h/%b want=%h/%b", i, s, co, es[i], ec[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] s; logic co; int lat; int bn; bit h; bit id; bit to;
        run_op(8'h80, 8'h80, 1'b1, 5, s, co, lat, bn, h, id, to);
        total++; if (to || s !== 8'h01 || co !== 1'b1) begin bad++; $display("FAIL bp_result got=%h/%b want=01/1", s, co); end
        total++; if (!h) begin bad++; $display("FAIL bp_hold got=%b want=1", h); end
        total++; if (!id) begin bad++; $display("FAIL bp_return_idle got=%b want=1", id); end
        total++; if (bn != 14) begin bad++; $display("FAIL bp_busy_cycles got=%0d want=14", bn); end
    endtask

    task automatic test_reset_mid_add();
        bit seen = 1'b0;
        a_in = 8'hAA; b_in = 8'h55; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        total++; if (sum_out !== 8'h00 || cout !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL midreset_outputs got=%h/%b/%b/%b want=00/0/0/0", sum_out, cout, out_valid, busy);
        end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midreset_in_ready got=%b want=1", in_ready); end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL midreset_no_valid got=1 want=0"); end
        out_ready = 1'b0;
    endtask

    task automatic test_busy_protection();
        int n = 0;
        a_in = 8'h01; b_in = 8'h02; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        a_in = 8'h11; b_in = 8'h22; cin = 1'b0; in_valid = 1'b1;
        while (!out_valid && n < 50) begin tick(); n++; end
        total++; if (!out_valid || sum_out !== 8'h03 || cout !== 1'b0) begin
            bad++; $display("FAIL busyprot_first got=%h/%b want=03/0", sum_out, cout);
        end
        tick();
        total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL busyprot_no_same_cycle busy=%b in_ready=%b want=0/1", busy, in_ready);
        end
        tick();
        in_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busyprot_second_accept got=%b want=1", busy); end
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        total++; if (!out_valid || sum_out !== 8'h33 || cout !== 1'b0) begin
            bad++; $display("FAIL busyprot_second got=%h/%b want=33/0", sum_out, cout);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int rise [2];
        int nr = 0;
        logic prev = busy;
        a_in = 8'h0F; b_in = 8'hF0; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (busy && !prev && nr < 2) begin rise[nr] = i; nr++; end
            prev = busy;
        end
        in_valid = 1'b0;
        total++; if (nr != 2 || rise[1] - rise[0] != WIDTH + 2) begin
            bad++; $display("FAIL b2b_period got=%0d want=%0d", (nr == 2) ? rise[1] - rise[0] : -1, WIDTH + 2);
        end
        n_wait_idle();
        out_ready = 1'b0;
    endtask

    task automatic n_wait_idle();
        int n = 0;
        out_ready = 1'b1;
        while (busy && n < 50) begin tick(); n++; end
    endtask

    task automatic test_random();
        logic [7:0] s; logic co; int lat; int bn; bit h; bit id; bit to;
        logic [7:0] a; logic [7:0] b; logic c;
        logic [8:0] ref_sum;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
            ref_sum = {1'b0, a} + {1'b0, b} + {8'h00, c};
            run_op(a, b, c, $urandom_range(0, 3), s, co, lat, bn, h, id, to);
            total++; if (to || s !== ref_sum[7:0] || co !== ref_sum[8] || !h || !id) begin
                bad++;
                $display("FAIL random%0d a=%h b=%h c=%b got=%h/%b want=%h/%b hold=%b idle=%b",
                         i, a, b, c, s, co, ref_sum[7:0], ref_sum[8], h, id);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; cin = 1'b0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_mid_add();
        test_busy_protection();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The parameter WIDTH SHALL default to 8 and set the operand width (legal range 2..32).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  the operand set on a_in/b_in/cin is valid.
REQ-005 in_ready  output  1  the block can accept an operand set.
REQ-006 a_in  input  WIDTH  addend A.
REQ-007 b_in  input  WIDTH  addend B.
REQ-008 cin  input  1  carry-in for the addition.
REQ-009 sum_out  output  WIDTH  registered sum of A+B+cin.
REQ-010 cout  output  1  registered carry-out of the MSB.
REQ-011 out_valid  output  1  sum_out/cout hold a valid result.
REQ-012 out_ready  input  1  the downstream consumer takes the result.
REQ-013 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in ADD and DONE, in_ready SHALL be 0.
REQ-016 Acceptance SHALL occur on an edge where in_valid=1 and in_ready=1: latch a_in into shift register A, b_in into shift register B, cin into the carry flop, clear the bit counter and sum register, and go to ADD.
REQ-017 In ADD, each cycle SHALL add A[0], B[0] and the carry flop through one instance of the team's 1-bit full_adder, with no other adder logic.
REQ-018 On each ADD edge, the full-adder sum bit SHALL shift into the sum register MSB (right shift); A and B SHALL shift right by 1; the carry flop SHALL take the full-adder carry; the counter SHALL increment.
REQ-019 The counter SHALL be ceil(log2(WIDTH+1)) bits wide; the edge that processes bit WIDTH-1 SHALL move the FSM to DONE.
REQ-020 Latency: if the accepting edge is edge 0, out_valid SHALL first be 1 after edge WIDTH.
REQ-021 In DONE, out_valid SHALL be 1, and sum_out/cout SHALL equal (A+B+cin) mod 2^WIDTH and bit WIDTH of that sum, respectively.
REQ-022 In DONE, sum_out, cout and out_valid SHALL hold stable while out_ready=0, for an unbounded number of cycles.
REQ-023 In DONE with out_ready=1, the next edge SHALL return the FSM to IDLE and clear out_valid; sum_out/cout SHALL keep their values until the next acceptance.
REQ-024 There SHALL be no same-cycle acceptance in DONE: an in_valid asserted at the same time as out_ready SHALL only be accepted on a later IDLE edge.
REQ-025 in_valid and operand changes while in ADD or DONE SHALL be ignored and SHALL NOT disturb the operation in progress.
REQ-026 out_valid SHALL never be 1 in IDLE or ADD.
REQ-027 Sustained throughput SHALL be one result per WIDTH+2 cycles.

Reset
REQ-028 When rst_n=0 on an edge, the FSM SHALL go to IDLE and every register SHALL clear: sum_out=0, cout=0, out_valid=0, busy=0, counter=0, carry=0, shift registers=0.
REQ-029 Because rst_n=0 forces IDLE, in_ready SHALL read 1 on the edge that applies the reset.
REQ-030 Reset applied during ADD or DONE SHALL abort the operation with no out_valid pulse; a result pending in DONE SHALL be discarded.
REQ-031 An in_valid present on the edge where rst_n=0 SHALL NOT be accepted.

Verification
REQ-032 With WIDTH=8, a_in=8'h5A, b_in=8'h3C, cin=0 and out_ready=1: out_valid SHALL rise 8 edges after acceptance with sum_out=8'h96 and cout=0, and busy SHALL be 1 for 9 cycles.
REQ-033 With a_in=8'hFF, b_in=8'h01, cin=0 the result SHALL be sum_out=8'h00, cout=1; with a_in=8'hFF, b_in=8'h00, cin=1 the result SHALL be sum_out=8'h00, cout=1.
REQ-034 Backpressure: with a_in=8'h80, b_in=8'h80, cin=1 and out_ready=0 for 5 cycles after out_valid rises, outputs SHALL hold at 8'h01/cout=1; out_ready=1 SHALL return the FSM to IDLE on the next edge.
REQ-035 Reset mid-ADD: assert rst_n=0 at bit 3 of a 8'hAA+8'h55 addition; all outputs SHALL be 0 next cycle, in_ready=1, and no out_valid SHALL occur.
REQ-036 Busy protection: assert in_valid with a_in=8'h11 during an ADD of 8'h01+8'h02; the result SHALL be 8'h03, and the second operand set SHALL be accepted only after DONE→IDLE.
REQ-037 Randomized check: at least 1000 random operand sets with random out_ready stalls SHALL compare sum_out/cout against a reference model.
